// File: rtl/alu_mdu_pipe.sv
// Registered execute-stage ALU with an iterative shift-add multiplier and restoring divider.
// Define ALU_MDU_SIGNED_DIV_EN to enable signed DIV (1110) and REM (1111).
module alu_mdu_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
`ifdef ALU_MDU_SIGNED_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;
`ifdef ALU_MDU_SIGNED_DIV_EN
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic              a_neg, b_neg;
`endif

    logic [XLEN-1:0]   alu_res, a_mag, b_mag, fin_res;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              accept, is_mul, is_div;

    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_AND:  alu_res = srca & srcb;
            OP_OR:   alu_res = srca | srcb;
            OP_XOR:  alu_res = srca ^ srcb;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
            OP_SLL:  alu_res = srca << srcb[SH_W-1:0];
            OP_SRL:  alu_res = srca >> srcb[SH_W-1:0];
            OP_SRA:  alu_res = $signed(srca) >>> srcb[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // Signed divides run on magnitudes; signs are reapplied when the result is loaded.
    always_comb begin
        is_mul = (alucontrol == OP_MUL) || (alucontrol == OP_MULHU);
        is_div = (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);
        a_mag  = srca;
        b_mag  = srcb;
`ifdef ALU_MDU_SIGNED_DIV_EN
        a_neg  = ((alucontrol == OP_DIV) || (alucontrol == OP_REM)) && srca[XLEN-1];
        b_neg  = ((alucontrol == OP_DIV) || (alucontrol == OP_REM)) && srcb[XLEN-1];
        is_div = is_div || (alucontrol == OP_DIV) || (alucontrol == OP_REM);
        if (a_neg) a_mag = -srca;
        if (b_neg) b_mag = -srcb;
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        fin_res   = acc_q[XLEN-1:0];
        case (op_q)
            OP_MULHU, OP_REMU: fin_res = acc_q[2*XLEN-1:XLEN];
`ifdef ALU_MDU_SIGNED_DIV_EN
            OP_DIV:  fin_res = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            OP_REM:  fin_res = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`endif
            default: fin_res = acc_q[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MDU_SIGNED_DIV_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MDU_SIGNED_DIV_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        op_d        = op_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef ALU_MDU_SIGNED_DIV_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        accept      = in_valid && in_ready;
        case (state_q)
            S_IDLE: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
                if (accept) begin
                    if (is_mul || is_div) begin
                        state_d = is_mul ? S_MUL : S_DIV;
                        cnt_d   = CNT_W'(XLEN);
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        op_d    = alucontrol;
`ifdef ALU_MDU_SIGNED_DIV_EN
                        qneg_d  = (a_neg ^ b_neg) && (srcb != '0);
                        rneg_d  = a_neg;
`endif
                    end else begin
                        result_d    = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    result_d    = fin_res;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        busy      = ((state_q == S_MUL) || (state_q == S_DIV)) && (cnt_q != '0);
        out_valid = out_valid_q;
        result    = result_q;
        zero      = (result_q == '0);
    end
endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed vector bench for alu_mdu_pipe at XLEN=32, with multi-cycle handshake sequences.
module tb_alu_mdu_pipe;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]      alucontrol;
    logic [XLEN-1:0] srca, srcb, result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          multi;
    } vec_t;
    vec_t vecs[$];

    alu_mdu_pipe #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit multi);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.multi = multi;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; returns once out_valid is seen (or a bound expires).
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output logic z,
                          output int lat, output int busy_n, output bit ir_seen);
        int w;
        alucontrol = op; srca = a; srcb = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) check({name, ".accept_timeout"}, 64'(w), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; srca = ~a; srcb = ~b; alucontrol = ~op;
        lat = 0; busy_n = 0; ir_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_n++;
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        res = result; z = zero;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat, busy_n;
        bit          ir_seen, seen;

        add_vec("add_5_7",       4'h0, 32'd5,          32'd7,          32'd12,         1'b0);
        add_vec("sub_9_9",       4'h1, 32'd9,          32'd9,          32'd0,          1'b0);
        add_vec("and",           4'h2, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000,  1'b0);
        add_vec("or",            4'h3, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFFF0_FFF0,  1'b0);
        add_vec("xor",           4'h4, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFF00_0FF0,  1'b0);
        add_vec("slt_m1_1",      4'h5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
        add_vec("sltu_m1_1",     4'h6, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
        add_vec("sll_by_33",     4'h7, 32'd1,          32'd33,         32'd2,          1'b0);
        add_vec("srl_4",         4'h8, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0);
        add_vec("sra_4",         4'h9, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0);
        add_vec("add_wrap",      4'h0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
        add_vec("mul_m1_2",      4'hA, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1);
        add_vec("mulhu_m1_2",    4'hB, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b1);
        add_vec("mul_1000sq",    4'hA, 32'd1000,       32'd1000,       32'd1000000,    1'b1);
        add_vec("mulhu_2p31sq",  4'hB, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b1);
        add_vec("divu_100_7",    4'hC, 32'd100,        32'd7,          32'd14,         1'b1);
        add_vec("remu_100_7",    4'hD, 32'd100,        32'd7,          32'd2,          1'b1);
        add_vec("divu_by_0",     4'hC, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1);
        add_vec("remu_55_by_0",  4'hD, 32'd55,         32'd0,          32'd55,         1'b1);
        add_vec("divu_max_1",    4'hC, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b1);
`ifdef ALU_MDU_SIGNED_DIV_EN
        add_vec("div_m7_2",      4'hE, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b1);
        add_vec("rem_m7_2",      4'hF, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b1);
        add_vec("div_7_m2",      4'hE, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b1);
        add_vec("rem_7_m2",      4'hF, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b1);
        add_vec("div_min_m1",    4'hE, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
        add_vec("rem_min_m1",    4'hF, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1);
        add_vec("div_m5_by_0",   4'hE, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1);
        add_vec("rem_m5_by_0",   4'hF, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1);
`else
        add_vec("op1110",        4'hE, 32'd123,        32'd45,         32'd0,          1'b0);
        add_vec("op1111",        4'hF, 32'd123,        32'd45,         32'd0,          1'b0);
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alucontrol = '0; srca = '0; srcb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.zero", 64'(zero), 64'd1);
        check("rst.busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, busy_n, ir_seen);
            check({vecs[i].name, ".result"}, 64'(res), 64'(vecs[i].exp));
            check({vecs[i].name, ".zero"}, 64'(z), 64'(vecs[i].exp == 32'd0));
            check({vecs[i].name, ".latency"}, 64'(lat), vecs[i].multi ? 64'(XLEN + 1) : 64'd0);
            if (vecs[i].multi) begin
                check({vecs[i].name, ".busy_cycles"}, 64'(busy_n), 64'(XLEN));
                check({vecs[i].name, ".in_ready_low"}, 64'(ir_seen), 64'd0);
            end
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: first result must hold while a second op waits unaccepted.
        out_ready = 1'b0;
        alucontrol = 4'h0; srca = 32'd3; srcb = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        alucontrol = 4'h1; srca = 32'd10; srcb = 32'd1;
        check("bp.first_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp.hold_result", 64'(result), 64'd7);
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.second_result", 64'(result), 64'd9);
        check("bp.second_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("bp.drained", 64'(out_valid), 64'd0);

        // Back-to-back single-cycle ops, one per clock.
        alucontrol = 4'h0; srca = 32'd1; srcb = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b.add", 64'(result), 64'd3);
        alucontrol = 4'h4; srca = 32'd5; srcb = 32'd3;
        @(posedge clk); #1;
        check("b2b.xor", 64'(result), 64'd6);
        alucontrol = 4'h1; srca = 32'd2; srcb = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b.sub", 64'(result), 64'hFFFF_FFFF);
        check("b2b.valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of a divide aborts it with no result.
        alucontrol = 4'hC; srca = 32'd100; srcb = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.in_ready", 64'(in_ready), 64'd1);
        check("abort.busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_result", 64'(seen), 64'd0);
        check("abort.in_ready_after", 64'(in_ready), 64'd1);
        run_op("recover", 4'h0, 32'd20, 32'd22, res, z, lat, busy_n, ir_seen);
        check("recover.result", 64'(res), 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_mdu_pipe.md
Name: alu_mdu_pipe

Overview:
- Parametrised successor to the combinational execute-stage ALU.
- Registered ALU plus an iterative multiply/divide unit behind a valid/ready handshake, so the EX stage can stall on long operations.
- Single-cycle ops return after 1 clock; MUL/DIV ops iterate one bit per clock.
- Sits in EX and drives the EX/MEM result and zero flag; hazard unit stalls while in_ready is low.

Parameters:
- XLEN, 32: operand/result width in bits; legal values 8..64.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation.
- alucontrol  in  4  operation select.
- srca  in  XLEN  operand A.
- srcb  in  XLEN  operand B.
- out_valid  out  1  result/zero valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- zero  out  1  high when result == 0.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset, asynchronous, rst_n low: state IDLE; in_ready=1 after reset, out_valid=0, result=0, zero=1, busy=0, counter=0.
- Reset asserted mid-operation aborts it; no result is emitted.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed, result 1/0), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount = srcb[$clog2(XLEN)-1:0].
  - 1010 MUL (low XLEN bits), 1011 MULHU (high XLEN bits, unsigned).
  - 1100 DIVU, 1101 REMU.
  - 1110/1111: see Optional Feature.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid holds, with result/zero stable, until out_ready is sampled high.
  - Back-to-back single-cycle ops sustain 1 per clock while out_ready=1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, single-cycle op accepted: result registered next edge; out_valid=1 the following cycle; stay IDLE.
  - IDLE, MUL op accepted: enter MUL, busy=1, counter=XLEN. Shift-add, one bit per cycle, 2*XLEN-bit accumulator, operands latched at accept.
  - IDLE, DIV/REM op accepted: enter DIV, busy=1, counter=XLEN. Restoring division, one quotient bit per cycle.
  - MUL/DIV: when counter reaches 0, go to DONE; result loaded, out_valid=1, busy=0.
  - DONE: on out_ready go to IDLE.
  - Latency of a multi-cycle op: out_valid rises exactly XLEN+1 cycles after the accept edge.
- Divide by zero is not an exception; it still takes XLEN+1 cycles. DIVU returns all-ones; REMU returns srca.
- Inputs are ignored while in_ready=0; operands are latched only at accept.
- zero is computed from the registered result and updates with it.

Optional Feature:
- Macro: ALU_MDU_SIGNED_DIV_EN.
- Defined:
  - 1110 = DIV (signed), 1111 = REM (signed).
  - Implementation: magnitudes through the unsigned divider, sign fixed in DONE. Quotient sign = sign(a)^sign(b); remainder takes sign of a.
  - Same XLEN+1 latency.
  - Divide by zero: DIV = -1, REM = srca.
  - Overflow case MIN/-1: DIV = MIN, REM = 0.
- Not defined: 1110/1111 complete as single-cycle ops with result=0, zero=1.

Test Plan:
- Reset then ADD 5+7, out_ready=1 -> out_valid next cycle, result=12, zero=0; SUB 9-9 -> result=0, zero=1.
- SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SLL by 33 -> shift by 1.
- MUL 0xFFFFFFFF×2 -> out_valid exactly 33 cycles after accept, busy high 32 cycles, result=0xFFFFFFFE; MULHU same operands -> 0x00000001; in_ready low throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 55/0 -> 55.
- Backpressure: ADD with out_ready=0 for 5 cycles -> result held stable, in_ready=0, second op not accepted until release.
- With ALU_MDU_SIGNED_DIV_EN: DIV -7/2 -> -3, REM -7/2 -> -1, DIV 0x80000000/-1 -> 0x80000000. Without the macro: opcode 1110 -> result 0 after 1 cycle. Also assert rst_n mid-DIV -> out_valid=0, in_ready=1 after release.
